// File: rtl/calci_pkg.sv
// Shared types and constants for the calci pipelined calculator.
package calci_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_MAC = 2'b11
    } op_e;

    localparam int CALCI_W     = 8;
    localparam int CALCI_DEPTH = 4;
    localparam int LAT         = 2;

endpackage

// File: rtl/calci_res_fifo.sv
// Result FIFO: circular buffer with wrap-around pointers and occupancy count.
module calci_res_fifo #(
    parameter int W_DATA = 16,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [W_DATA-1:0]        din,
    input  logic                     pop,
    output logic [W_DATA-1:0]        dout,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W_DATA-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wptr_q, wptr_d;
    logic [AW-1:0]     rptr_q, rptr_d;
    logic [AW:0]       cnt_q, cnt_d;
    logic              do_pop;

    always_comb begin
        do_pop = pop & ~empty;
        wptr_d = push ? wptr_q + AW'(1) : wptr_q;
        rptr_d = do_pop ? rptr_q + AW'(1) : rptr_q;
        cnt_d  = cnt_q + (AW+1)'(push) - (AW+1)'(do_pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
            if (push) mem_q[wptr_q] <= din;
        end
    end

    assign empty = (cnt_q == '0);
    assign full  = (cnt_q == (AW+1)'(DEPTH));
    assign level = cnt_q;
    assign dout  = empty ? '0 : mem_q[rptr_q];

    // Upstream stall accounting guarantees space for every push.
    a_no_push_full : assert property (
        @(posedge clk) disable iff (!rst_n) !(push && full)
    );

endmodule

// File: rtl/calci_pipe_core.sv
// Two-stage ADD/SUB/MUL/MAC datapath feeding a result FIFO.
module calci_pipe_core
    import calci_pkg::*;
#(
    parameter int W     = CALCI_W,
    parameter int DEPTH = CALCI_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       Valid,
    output logic                       Stall,
    input  logic [W-1:0]               A,
    input  logic [W-1:0]               B,
    input  logic [1:0]                 ctrl,
    input  logic                       acc_clr,
    output logic [2*W-1:0]             C,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int LW = $clog2(DEPTH) + 1;
    localparam int RW = 2 * W;

    logic          accept;
    logic [RW-1:0] prod_in, acc_base, acc_d, acc_q;

    logic          s1_vld_q, s1_vld_d;
    logic [W-1:0]  s1_a_q, s1_a_d, s1_b_q, s1_b_d;
    op_e           s1_op_q, s1_op_d;
    logic [RW-1:0] s1_mac_q, s1_mac_d;

    logic          s2_vld_q, s2_vld_d;
    logic [RW-1:0] s2_res_q, s2_res_d, res;

    logic [LW:0]   occ;
    logic          fifo_full, fifo_empty;

    // Occupancy counts in-flight work; a same-cycle pop is not credited.
    assign occ = {1'b0, level} + (LW+1)'(s1_vld_q) + (LW+1)'(s2_vld_q);
    assign Stall = (occ >= (LW+1)'(DEPTH));
    assign accept = Valid & ~Stall;
    assign out_valid = ~fifo_empty;

    always_comb begin
        prod_in  = RW'(A) * RW'(B);
        acc_base = acc_clr ? '0 : acc_q;
        acc_d    = acc_base;
        if (accept && op_e'(ctrl) == OP_MAC) acc_d = acc_base + prod_in;

        s1_vld_d = accept;
        s1_a_d   = accept ? A : s1_a_q;
        s1_b_d   = accept ? B : s1_b_q;
        s1_op_d  = accept ? op_e'(ctrl) : s1_op_q;
        s1_mac_d = accept ? acc_d : s1_mac_q;
    end

    always_comb begin
        res = '0;
        unique case (s1_op_q)
            OP_ADD: res = RW'(s1_a_q) + RW'(s1_b_q);
            OP_SUB: res = RW'(s1_a_q) - RW'(s1_b_q);
            OP_MUL: res = RW'(s1_a_q) * RW'(s1_b_q);
            OP_MAC: res = s1_mac_q;
        endcase
        s2_vld_d = s1_vld_q;
        s2_res_d = s1_vld_q ? res : s2_res_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q    <= '0;
            s1_vld_q <= 1'b0;
            s1_a_q   <= '0;
            s1_b_q   <= '0;
            s1_op_q  <= OP_ADD;
            s1_mac_q <= '0;
            s2_vld_q <= 1'b0;
            s2_res_q <= '0;
        end else begin
            acc_q    <= acc_d;
            s1_vld_q <= s1_vld_d;
            s1_a_q   <= s1_a_d;
            s1_b_q   <= s1_b_d;
            s1_op_q  <= s1_op_d;
            s1_mac_q <= s1_mac_d;
            s2_vld_q <= s2_vld_d;
            s2_res_q <= s2_res_d;
        end
    end

    calci_res_fifo #(
        .W_DATA (RW),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (s2_vld_q),
        .din   (s2_res_q),
        .pop   (out_ready),
        .dout  (C),
        .level (level),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

endmodule

// File: tb/tb_calci_pipe_core.sv
// Scoreboard bench for calci_pipe_core: driver queues expectations, monitor checks.
module tb_calci_pipe_core;
    import calci_pkg::*;

    localparam int W     = 8;
    localparam int DEPTH = 4;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            Valid = 1'b0;
    logic            Stall;
    logic [W-1:0]    A = '0;
    logic [W-1:0]    B = '0;
    logic [1:0]      ctrl = 2'b00;
    logic            acc_clr = 1'b0;
    logic [2*W-1:0]  C;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [LW-1:0]   level;

    logic [2*W-1:0]  exp_q[$];
    int              n_chk = 0;
    int              n_fail = 0;
    int              stall_cnt = 0;
    int              s0;

    calci_pipe_core #(.W(W), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .Valid     (Valid),
        .Stall     (Stall),
        .A         (A),
        .B         (B),
        .ctrl      (ctrl),
        .acc_clr   (acc_clr),
        .C         (C),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .level     (level)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT hands over a result.
    logic [2*W-1:0] mon_e;
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_result: got %0h expected none", C);
            end else begin
                mon_e = exp_q.pop_front();
                check("result", {16'h0, C}, {16'h0, mon_e});
            end
        end
    end

    task automatic send(input logic [7:0] a, input logic [7:0] b,
                        input op_e op, input logic clr,
                        input logic [15:0] e);
        bit ok;
        ok = 1'b0;
        Valid = 1'b1;
        A = a;
        B = b;
        ctrl = op;
        acc_clr = clr;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (!Stall) begin
                ok = 1'b1;
                break;
            end
            stall_cnt++;
        end
        if (ok) exp_q.push_back(e);
        else begin
            n_chk++;
            n_fail++;
            $display("FAIL accept_timeout: got stalled expected accept");
        end
        @(posedge clk);
        #1;
        Valid = 1'b0;
        acc_clr = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        out_ready = 1'b1;
        while ((exp_q.size() != 0 || out_valid) && t < 200) begin
            @(posedge clk);
            #1;
            t++;
        end
        check("drain_queue", exp_q.size(), 0);
        check("drain_out_valid", {31'h0, out_valid}, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_C", {16'h0, C}, 0);
        check("rst_out_valid", {31'h0, out_valid}, 0);
        check("rst_level", {29'h0, level}, 0);
        check("rst_Stall", {31'h0, Stall}, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Latency of the first ADD with the consumer held off
        out_ready = 1'b0;
        send(8'hFF, 8'h01, OP_ADD, 1'b0, 16'h0100);
        for (int i = 0; i < LAT; i++) begin
            @(negedge clk);
            check("lat_before", {31'h0, out_valid}, 0);
        end
        @(negedge clk);
        check("lat_at", {31'h0, out_valid}, 1);
        check("lat_C", {16'h0, C}, 32'h0100);
        @(posedge clk);
        #1;
        out_ready = 1'b1;

        send(8'h03, 8'h05, OP_SUB, 1'b0, 16'hFFFE);
        send(8'hFF, 8'hFF, OP_MUL, 1'b0, 16'hFE01);
        send(8'd2, 8'd3, OP_MAC, 1'b1, 16'd6);
        send(8'd4, 8'd5, OP_MAC, 1'b0, 16'd26);
        send(8'd1, 8'd1, OP_MAC, 1'b0, 16'd27);
        drain();

        // Accumulator wrap and clear interactions
        send(8'hFF, 8'hFF, OP_MAC, 1'b1, 16'hFE01);
        send(8'hFF, 8'h02, OP_MAC, 1'b0, 16'hFFFF);
        send(8'h20, 8'h20, OP_MAC, 1'b0, 16'h03FF);
        send(8'h01, 8'h01, OP_ADD, 1'b1, 16'h0002);
        send(8'h01, 8'h01, OP_MAC, 1'b0, 16'h0001);
        drain();

        // Backpressure: fill to DEPTH with the consumer stalled
        out_ready = 1'b0;
        s0 = stall_cnt;
        send(8'd1, 8'd1, OP_ADD, 1'b0, 16'd2);
        send(8'd2, 8'd2, OP_ADD, 1'b0, 16'd4);
        send(8'd3, 8'd3, OP_ADD, 1'b0, 16'd6);
        send(8'd4, 8'd4, OP_ADD, 1'b0, 16'd8);
        check("fill_no_stall", stall_cnt - s0, 0);
        @(negedge clk);
        check("fill_stall", {31'h0, Stall}, 1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("full_level", {29'h0, level}, 4);
        check("full_stall", {31'h0, Stall}, 1);
        check("full_head", {16'h0, C}, 2);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        check("release_stall_hold", {31'h0, Stall}, 1);
        @(negedge clk);
        check("release_level", {29'h0, level}, 3);
        check("release_stall_drop", {31'h0, Stall}, 0);
        @(posedge clk);
        #1;
        send(8'd5, 8'd5, OP_ADD, 1'b0, 16'd10);
        drain();

        // Continuous streaming with the consumer always ready
        s0 = stall_cnt;
        for (int i = 0; i < 20; i++) begin
            logic [7:0] a, b;
            a = 8'(i * 11 + 7);
            b = 8'(250 - i * 3);
            send(a, b, OP_ADD, 1'b0, {8'h0, a} + {8'h0, b});
        end
        check("stream_no_stall", stall_cnt - s0, 0);
        drain();

        // Reset with two results queued and two in flight
        out_ready = 1'b0;
        send(8'd3, 8'd3, OP_MAC, 1'b1, 16'd9);
        send(8'd1, 8'd1, OP_MAC, 1'b0, 16'd10);
        send(8'd2, 8'd5, OP_MAC, 1'b0, 16'd20);
        send(8'd7, 8'd1, OP_ADD, 1'b0, 16'd8);
        check("pre_rst_level", {29'h0, level}, 2);
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", {31'h0, out_valid}, 0);
        check("mid_rst_level", {29'h0, level}, 0);
        check("mid_rst_Stall", {31'h0, Stall}, 0);
        check("mid_rst_C", {16'h0, C}, 0);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        send(8'd2, 8'd2, OP_MAC, 1'b0, 16'd4);
        repeat (8) @(posedge clk);
        #1;
        check("post_rst_queue", exp_q.size(), 0);
        check("post_rst_out_valid", {31'h0, out_valid}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
